// File: rtl/adc_pkg.sv
// Constants and state type shared by the ADC SPI master and the responder model.
package adc_pkg;

    localparam int ADC_DATA_W     = 12;
    localparam int ADC_NUM_CH     = 8;
    localparam int ADC_ADDR_W     = 3;
    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_LEAD_ZEROS = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } adc_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by an edge-detect
// register that produces one-cycle rise/fall pulses.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Responder end of the serial ADC link: decodes the channel address on ADC_DIN and
// returns {leading zeros, sample} frames on ADC_DOUT, MSB first.
module adc_spi_responder
    import adc_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int NUM_CH      = ADC_NUM_CH,
    parameter int ADDR_W      = ADC_ADDR_W,
    parameter int FRAME_BITS  = ADC_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     ADC_SCLK,
    input  logic                     ADC_CS_N,
    input  logic                     ADC_DIN,
    input  logic [NUM_CH*DATA_W-1:0] CH_DATA,
    output logic                     ADC_DOUT,
    output logic                     ADC_DOUT_OE,
    output logic [ADDR_W-1:0]        CUR_CH,
    output logic [ADDR_W-1:0]        NEXT_CH,
    output logic                     FRAME_DONE,
    output logic                     FRAME_ERR
);

    localparam int CNT_W = $clog2(FRAME_BITS) + 1;
    localparam int SC_W  = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] RISE_LAST  = CNT_W'(FRAME_BITS);
    localparam logic [SC_W-1:0]  SHIFT_LAST = SC_W'(FRAME_BITS - 1);
    localparam int unsigned ADDR_FIRST_RISE = 3;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic din_lvl, din_rise, din_fall;
    logic [2:0] sync_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(CLOCK), .rst(RESET), .d(ADC_SCLK),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(CLOCK), .rst(RESET), .d(ADC_CS_N),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
        .clk(CLOCK), .rst(RESET), .d(ADC_DIN),
        .level(din_lvl), .rise(din_rise), .fall(din_fall)
    );

    assign sync_unused = {sclk_lvl, din_rise, din_fall};

    adc_state_t             state_q, state_d;
    logic [FRAME_BITS-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0]       rc_q, rc_d, rc_n;
    logic [SC_W-1:0]        sc_q, sc_d;
    logic                   skip_q, skip_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W-1:0]      cur_q, cur_d;
    logic [ADDR_W-1:0]      next_q, next_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    // Channels beyond NUM_CH read as zero.
    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic [NUM_CH*DATA_W-1:0] bus,
        input logic [ADDR_W-1:0]        idx
    );
        logic [DATA_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(idx) == i) s = bus[i*DATA_W +: DATA_W];
        end
        return {{(FRAME_BITS-DATA_W){1'b0}}, s};
    endfunction

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            sr_q    <= '0;
            rc_q    <= '0;
            sc_q    <= '0;
            skip_q  <= 1'b0;
            addr_q  <= '0;
            cur_q   <= '0;
            next_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rc_q    <= rc_d;
            sc_q    <= sc_d;
            skip_q  <= skip_d;
            addr_q  <= addr_d;
            cur_q   <= cur_d;
            next_q  <= next_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rc_d    = rc_q;
        rc_n    = rc_q;
        sc_d    = sc_q;
        skip_d  = skip_q;
        addr_d  = addr_q;
        cur_d   = cur_q;
        next_d  = next_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    sr_d    = frame_word(CH_DATA, next_q);
                    cur_d   = next_q;
                    rc_d    = '0;
                    sc_d    = '0;
                    skip_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (sclk_fall) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (sc_q != SHIFT_LAST) begin
                        sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
                        sc_d = sc_q + SC_W'(1);
                    end
                end
                if (sclk_rise) begin
                    if (rc_q != RISE_LAST) rc_n = rc_q + CNT_W'(1);
                    rc_d = rc_n;
                    for (int unsigned i = 0; i < ADDR_W; i++) begin
                        if (rc_n == CNT_W'(ADDR_FIRST_RISE + i)) addr_d[ADDR_W-1-i] = din_lvl;
                    end
                    // Completion wins over a coincident CS_N rise; only a held CS_N reloads.
                    if (rc_n == RISE_LAST && rc_q != RISE_LAST) begin
                        next_d = addr_d;
                        done_d = 1'b1;
                        if (!cs_lvl) begin
                            sr_d   = frame_word(CH_DATA, addr_d);
                            cur_d  = addr_d;
                            rc_d   = '0;
                            sc_d   = '0;
                            skip_d = 1'b1;
                        end
                    end
                end
                if (cs_rise) begin
                    state_d = IDLE;
                    if (rc_n != '0 && rc_n != RISE_LAST) err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ADC_DOUT    = sr_q[FRAME_BITS-1];
    assign ADC_DOUT_OE = (state_q == SHIFT);
    assign CUR_CH      = cur_q;
    assign NEXT_CH     = next_q;
    assign FRAME_DONE  = done_q;
    assign FRAME_ERR   = err_q;

endmodule
